// File: rtl/wb_csr_file.sv
// wb_csr_file: machine-mode CSR file with mcycle/minstret performance counters.
//
// Ports:
//   clk_i           core clock
//   n_rst_i         asynchronous active-low reset
//   csr_we_i        CSR write strobe from writeback
//   csr_waddr_i     CSR write address (bits [11:0] decoded)
//   csr_wdata_i     CSR write data
//   instret_incr_i  one instruction retired this cycle
//   csr_raddr_i     CSR read address from execute (bits [11:0] decoded)
//   csr_rdata_o     combinational read data, write-first bypass
//   csr_illegal_o   read address is unmapped
//   mstatus_mie_o   registered mstatus.MIE
//   mie_o           registered mie
//   mtvec_o         registered mtvec
//   mepc_o          registered mepc
//
// Configuration macro: CSR_COUNTERS_EN builds the 64-bit mcycle/minstret counters and
// mcountinhibit. Without it those addresses stay mapped but read 0 and ignore writes.
module wb_csr_file (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        csr_we_i,
    input  logic [31:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        instret_incr_i,
    input  logic [31:0] csr_raddr_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    output logic        mstatus_mie_o,
    output logic [31:0] mie_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o
);
    localparam logic [11:0] AddrMstatus       = 12'h300;
    localparam logic [11:0] AddrMie           = 12'h304;
    localparam logic [11:0] AddrMtvec         = 12'h305;
    localparam logic [11:0] AddrMcountinhibit = 12'h320;
    localparam logic [11:0] AddrMscratch      = 12'h340;
    localparam logic [11:0] AddrMepc          = 12'h341;
    localparam logic [11:0] AddrMcause        = 12'h342;
    localparam logic [11:0] AddrMtval         = 12'h343;
    localparam logic [11:0] AddrMcycle        = 12'hB00;
    localparam logic [11:0] AddrMcycleh       = 12'hB80;
    localparam logic [11:0] AddrMinstret      = 12'hB02;
    localparam logic [11:0] AddrMinstreth     = 12'hB82;
    localparam logic [11:0] AddrCycle         = 12'hC00;
    localparam logic [11:0] AddrCycleh        = 12'hC80;
    localparam logic [11:0] AddrInstret       = 12'hC02;
    localparam logic [11:0] AddrInstreth      = 12'hC82;

    logic [11:0] waddr;
    logic [11:0] raddr;
    logic        wr_hit;
    logic        wr_en;
    logic [31:0] wr_val;
    logic        unused_addr;

    assign waddr       = csr_waddr_i[11:0];
    assign raddr       = csr_raddr_i[11:0];
    assign unused_addr = ^{csr_waddr_i[31:12], csr_raddr_i[31:12]};

    // Writable-register decode and write mask; wr_val is the value the register will take.
    always_comb begin
        wr_hit = 1'b1;
        wr_val = csr_wdata_i;
        case (waddr)
            AddrMstatus:                                 wr_val = csr_wdata_i & 32'h0000_0088;
            AddrMie, AddrMscratch, AddrMcause, AddrMtval: wr_val = csr_wdata_i;
            AddrMtvec, AddrMepc:                         wr_val = {csr_wdata_i[31:2], 2'b00};
`ifdef CSR_COUNTERS_EN
            AddrMcountinhibit:                           wr_val = csr_wdata_i & 32'h0000_0005;
            AddrMcycle, AddrMcycleh,
            AddrMinstret, AddrMinstreth:                 wr_val = csr_wdata_i;
`endif
            default: begin
                wr_hit = 1'b0;
                wr_val = '0;
            end
        endcase
    end

    assign wr_en = csr_we_i & wr_hit;

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (wr_en) begin
            case (waddr)
                AddrMstatus:  mstatus_d  = wr_val;
                AddrMie:      mie_d      = wr_val;
                AddrMtvec:    mtvec_d    = wr_val;
                AddrMscratch: mscratch_d = wr_val;
                AddrMepc:     mepc_d     = wr_val;
                AddrMcause:   mcause_d   = wr_val;
                AddrMtval:    mtval_d    = wr_val;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    logic [63:0] cyc_rd;
    logic [63:0] ins_rd;
    logic [31:0] inh_rd;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d, cy_sum;
    logic [63:0] minstret_q, minstret_d, ir_sum;
    logic [31:0] mcountinhibit_q, mcountinhibit_d;

    // A low-half write overrides the increment with no carry; a high-half write keeps the
    // low-half increment but drops its carry.
    always_comb begin
        cy_sum          = mcycle_q + {63'b0, ~mcountinhibit_q[0]};
        ir_sum          = minstret_q + {63'b0, instret_incr_i & ~mcountinhibit_q[2]};
        mcycle_d        = cy_sum;
        minstret_d      = ir_sum;
        mcountinhibit_d = mcountinhibit_q;
        if (wr_en) begin
            case (waddr)
                AddrMcycle:        mcycle_d        = {mcycle_q[63:32], wr_val};
                AddrMcycleh:       mcycle_d        = {wr_val, cy_sum[31:0]};
                AddrMinstret:      minstret_d      = {minstret_q[63:32], wr_val};
                AddrMinstreth:     minstret_d      = {wr_val, ir_sum[31:0]};
                AddrMcountinhibit: mcountinhibit_d = wr_val;
                default:           ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            mcycle_q        <= '0;
            minstret_q      <= '0;
            mcountinhibit_q <= '0;
        end else begin
            mcycle_q        <= mcycle_d;
            minstret_q      <= minstret_d;
            mcountinhibit_q <= mcountinhibit_d;
        end
    end

    assign cyc_rd = mcycle_q;
    assign ins_rd = minstret_q;
    assign inh_rd = mcountinhibit_q;
`else
    logic unused_incr;

    assign unused_incr = instret_incr_i;
    assign cyc_rd      = '0;
    assign ins_rd      = '0;
    assign inh_rd      = '0;
`endif

    // Read mux with write-first bypass; only writable addresses can set wr_en, so the
    // bypass never touches the read-only shadows or the illegal flag.
    always_comb begin
        csr_rdata_o   = '0;
        csr_illegal_o = 1'b0;
        case (raddr)
            AddrMstatus:                csr_rdata_o = mstatus_q;
            AddrMie:                    csr_rdata_o = mie_q;
            AddrMtvec:                  csr_rdata_o = mtvec_q;
            AddrMcountinhibit:          csr_rdata_o = inh_rd;
            AddrMscratch:               csr_rdata_o = mscratch_q;
            AddrMepc:                   csr_rdata_o = mepc_q;
            AddrMcause:                 csr_rdata_o = mcause_q;
            AddrMtval:                  csr_rdata_o = mtval_q;
            AddrMcycle, AddrCycle:      csr_rdata_o = cyc_rd[31:0];
            AddrMcycleh, AddrCycleh:    csr_rdata_o = cyc_rd[63:32];
            AddrMinstret, AddrInstret:  csr_rdata_o = ins_rd[31:0];
            AddrMinstreth, AddrInstreth: csr_rdata_o = ins_rd[63:32];
            default:                    csr_illegal_o = 1'b1;
        endcase
        if (wr_en && (waddr == raddr)) begin
            csr_rdata_o = wr_val;
        end
    end

    assign mstatus_mie_o = mstatus_q[3];
    assign mie_o         = mie_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;

endmodule
